// File: rtl/ps_loop_ctrl_pkg.sv
// Shared sequencer definitions for the hardware loop controller.
// Holds the default stack depth, the address width and the loop-entry layout.
package ps_loop_ctrl_pkg;

  localparam int unsigned LP_DEPTH = 4;
  localparam int unsigned ADDR_W   = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] count;
  } lp_entry_t;

endpackage

// File: rtl/ps_loop_stk.sv
// Loop stack storage: one pop, one push and one top-count write per cycle.
// When pop and push are both asserted, the top entry is replaced.
module ps_loop_stk #(
  parameter int unsigned LP_DEPTH = ps_loop_ctrl_pkg::LP_DEPTH,
  parameter int unsigned PTR_W    = $clog2(LP_DEPTH + 1)
) (
  input  logic                                  clk_fetch,
  input  logic                                  rst,
  input  logic                                  i_flush,
  input  logic                                  i_pop,
  input  logic                                  i_push,
  input  ps_loop_ctrl_pkg::lp_entry_t           i_push_entry,
  input  logic                                  i_top_wr,
  input  logic [ps_loop_ctrl_pkg::ADDR_W-1:0]   i_top_count,
  output ps_loop_ctrl_pkg::lp_entry_t           o_top,
  output logic [PTR_W-1:0]                      o_ptr
);
  import ps_loop_ctrl_pkg::*;

  localparam int unsigned IDX_W = (LP_DEPTH > 1) ? $clog2(LP_DEPTH) : 1;

  lp_entry_t        r_mem [LP_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_pop;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_ptr_pop = i_pop ? (r_ptr - PTR_W'(1)) : r_ptr;
  assign w_top_idx = IDX_W'(r_ptr - PTR_W'(1));
  assign w_wr_idx  = IDX_W'(w_ptr_pop);
  assign o_top     = (r_ptr == '0) ? lp_entry_t'('0) : r_mem[w_top_idx];
  assign o_ptr     = r_ptr;

  // The control block guarantees a top write never coincides with a pop,
  // so the top slot and the push slot are always distinct.
  always_ff @(posedge clk_fetch or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
      r_mem <= '{default: '0};
    end else if (i_flush) begin
      r_ptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[w_wr_idx] <= i_push_entry;
        r_ptr           <= w_ptr_pop + PTR_W'(1);
      end else begin
        r_ptr <= w_ptr_pop;
      end
      if (i_top_wr) begin
        r_mem[w_top_idx].count <= i_top_count;
      end
    end
  end

endmodule

// File: rtl/ps_loop_ctrl.sv
// Zero-overhead DO-UNTIL loop controller: detects the loop end address,
// redirects fetch to the body start and retires exhausted loops.
module ps_loop_ctrl #(
  parameter int unsigned LP_DEPTH = ps_loop_ctrl_pkg::LP_DEPTH,
  parameter int unsigned ADDR_W   = ps_loop_ctrl_pkg::ADDR_W
) (
  input  logic              clk_fetch,
  input  logic              rst,
  input  logic              stallb,
  input  logic              lp_push,
  input  logic [ADDR_W-1:0] lp_start_addr,
  input  logic [ADDR_W-1:0] lp_end_addr,
  input  logic [ADDR_W-1:0] lp_count,
  input  logic              lp_pop_req,
  input  logic              lp_flush,
  input  logic [ADDR_W-1:0] ps_faddr,
  output logic              lp_jmp,
  output logic [ADDR_W-1:0] lp_jmp_addr,
  output logic              lp_done,
  output logic [ADDR_W-1:0] lp_curlcntr,
  output logic              lp_empty,
  output logic              lp_full,
  output logic              lp_ovf
);
  import ps_loop_ctrl_pkg::*;

  localparam int unsigned PTR_W = $clog2(LP_DEPTH + 1);

  lp_entry_t        w_top;
  lp_entry_t        w_push_entry;
  logic [PTR_W-1:0] w_ptr;
  logic             w_active;
  logic             w_match;
  logic             w_match_jmp;
  logic             w_match_pop;
  logic             w_push_val;
  logic             w_skip;
  logic             w_pop;
  logic             w_push;
  logic             w_top_wr;
  logic             w_full_after;
  logic             r_done;
  logic             r_ovf;

  assign w_active    = stallb & ~lp_flush;
  assign lp_empty    = (w_ptr == '0);
  assign lp_full     = (w_ptr == PTR_W'(LP_DEPTH));
  assign w_match     = ~lp_empty & stallb & (ps_faddr == w_top.end_addr);
  assign w_match_jmp = w_match & (w_top.count > ADDR_W'(1));
  assign w_match_pop = w_match & ~w_match_jmp;

  assign w_push_val  = lp_push & (lp_count != '0);
  assign w_skip      = stallb & lp_push & (lp_count == '0);

  // Match acts on the old top first; a pop frees a slot for a same-cycle push.
  assign w_pop        = w_active & (w_match_pop | (lp_pop_req & ~lp_empty));
  assign w_top_wr     = w_active & w_match_jmp & ~w_pop;
  assign w_full_after = lp_full & ~w_pop;
  assign w_push       = w_active & w_push_val & ~w_full_after;

  assign w_push_entry = '{start_addr: lp_start_addr,
                          end_addr:   lp_end_addr,
                          count:      lp_count};

  assign lp_jmp      = rst & ~lp_flush & (w_match_jmp | w_skip);
  assign lp_jmp_addr = (w_skip & ~w_match_jmp) ? (lp_end_addr + ADDR_W'(1))
                                               : w_top.start_addr;
  assign lp_curlcntr = w_top.count;
  assign lp_done     = r_done & stallb;
  assign lp_ovf      = r_ovf;

  ps_loop_stk #(
    .LP_DEPTH (LP_DEPTH),
    .PTR_W    (PTR_W)
  ) u_stk (
    .clk_fetch    (clk_fetch),
    .rst          (rst),
    .i_flush      (stallb & lp_flush),
    .i_pop        (w_pop),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_top_wr     (w_top_wr),
    .i_top_count  (w_top.count - ADDR_W'(1)),
    .o_top        (w_top),
    .o_ptr        (w_ptr)
  );

  // Termination pulse and sticky overflow.
  always_ff @(posedge clk_fetch or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= w_active & w_match_pop;
      if (w_active & w_push_val & w_full_after) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule
